// File: rtl/vedic_mult_seq.sv
// Sequential Vedic multiplier: one 2-bit digit of |b| per cycle through a row of 2x2 crosswise/vertical cells.
// Latency: out_valid rises WIDTH/2 cycles after the accept edge; one product per WIDTH/2+2 cycles.
// Backpressure: in_ready only in IDLE; p/out_valid held in DONE until out_ready.
module vedic_mult_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               signed_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] p,
    output logic               busy
);
    localparam int DIGITS = WIDTH / 2;
    localparam int CW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PW     = 2 * WIDTH;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  mag_a, mag_b;
    logic              neg;
    logic [CW-1:0]     cnt;
    logic [PW-1:0]     acc;

    logic [WIDTH-1:0]  abs_a, abs_b;
    logic [1:0]        digit_b;
    logic [WIDTH+1:0]  row;
    logic [PW-1:0]     acc_next, prod_final;
    logic              last_digit;

    // 2x2 cell: vertical x0y0, crosswise x1y0+x0y1, vertical x1y1 with carry
    function automatic logic [3:0] vedic2x2(input logic [1:0] x, input logic [1:0] y);
        logic v0, c_a, c_b, v1;
        v0  = x[0] & y[0];
        c_a = x[1] & y[0];
        c_b = x[0] & y[1];
        v1  = x[1] & y[1];
        return {v1 & c_a & c_b, v1 ^ (c_a & c_b), c_a ^ c_b, v0};
    endfunction

    // Magnitude of -2^(WIDTH-1) wraps to itself, which is the correct unsigned value
    assign abs_a = (signed_mode && a[WIDTH-1]) ? (~a + 1'b1) : a;
    assign abs_b = (signed_mode && b[WIDTH-1]) ? (~b + 1'b1) : b;

    assign digit_b    = mag_b[2*cnt +: 2];
    assign last_digit = (cnt == CW'(DIGITS - 1));

    always_comb begin
        row = '0;
        for (int i = 0; i < DIGITS; i++) begin
            row = row + ((WIDTH+2)'(vedic2x2(mag_a[2*i +: 2], digit_b)) << (2 * i));
        end
    end

    assign acc_next   = acc + (PW'(row) << (2 * cnt));
    assign prod_final = neg ? (~acc_next + 1'b1) : acc_next;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)   state_d = BUSY;
            BUSY:    if (last_digit) state_d = DONE;
            DONE:    if (out_ready)  state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mag_a <= '0;
            mag_b <= '0;
            neg   <= 1'b0;
            cnt   <= '0;
            acc   <= '0;
            p     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        mag_a <= abs_a;
                        mag_b <= abs_b;
                        neg   <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                        acc   <= '0;
                        cnt   <= '0;
                    end
                end
                BUSY: begin
                    acc <= acc_next;
                    cnt <= cnt + CW'(1);
                    // p only ever takes the finished, sign-corrected product
                    if (last_digit) p <= prod_final;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);

endmodule

// File: doc/vedic_mult_seq.md
VEDIC_MULT_SEQ -- requirements
Module: vedic_mult_seq

Interface
REQ-001 Parameter WIDTH, default 8: operand width in bits; SHALL be even and >= 4 (legal: 4, 8, 16, 32).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 in_valid  input  1  operand pair presented.
REQ-005 in_ready  output  1  block can accept operands.
REQ-006 a  input  WIDTH  multiplicand.
REQ-007 b  input  WIDTH  multiplier.
REQ-008 signed_mode  input  1  1 = two's-complement operands/product, 0 = unsigned; sampled with a/b.
REQ-009 out_valid  output  1  product available.
REQ-010 out_ready  input  1  consumer accepts product.
REQ-011 p  output  2*WIDTH  product.
REQ-012 busy  output  1  high in any state other than IDLE.

Function
REQ-013 FSM states IDLE, BUSY, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-014 Accept: in IDLE with in_valid=1 on an edge -> latch a, b, signed_mode; clear accumulator; digit counter = 0; go to BUSY.
REQ-015 in_valid in BUSY or DONE SHALL be ignored; operands not latched; no state change.
REQ-016 Signed mode: latch |a|, |b| as WIDTH-bit unsigned magnitudes and a negate flag = sign(a) XOR sign(b); unsigned mode: magnitudes = a, b, negate = 0.
REQ-017 |−2^(WIDTH−1)| SHALL be represented as unsigned 2^(WIDTH−1) without overflow.
REQ-018 BUSY: each cycle processes one 2-bit digit of |b| (LSB digit first); a row of WIDTH/2 2x2 Vedic cells (crosswise/vertical form) multiplies that digit by every 2-bit digit of |a|; row sum shifted left by 2*counter is added to a 2*WIDTH-bit accumulator.
REQ-019 Counter increments each BUSY cycle; after digit WIDTH/2−1 is added, state -> DONE.
REQ-020 Latency: out_valid rises exactly WIDTH/2 cycles after the accept edge (WIDTH=8: 4 cycles).
REQ-021 On entry to DONE, p = accumulator, two's-complement negated (mod 2^(2*WIDTH)) when negate=1; p never shows intermediate sums.
REQ-022 DONE: p and out_valid held stable while out_ready=0.
REQ-023 DONE with out_ready=1 on an edge -> IDLE; out_valid=0 and in_ready=1 from next cycle; p retains last value.
REQ-024 out_ready outside DONE SHALL have no effect.
REQ-025 Arithmetic exact for all inputs: unsigned result = a*b mod 2^(2*WIDTH) (no wrap occurs); signed result fits 2*WIDTH bits including (−2^(WIDTH−1))^2.
REQ-026 Max throughput: one product per WIDTH/2+2 cycles (accept, WIDTH/2 BUSY, handoff).

Reset
REQ-027 rst=1 on an edge -> state IDLE, p=0, accumulator=0, counter=0, negate=0; out_valid=0, busy=0, in_ready=1 from next cycle.
REQ-028 rst takes priority over every event, including mid-BUSY and in DONE with out_ready=1; the in-flight operation is discarded, no out_valid is produced for it.
REQ-029 in_valid asserted in the same cycle as rst SHALL NOT be accepted.

Verification
REQ-030 WIDTH=8, unsigned, a=0xFF, b=0xFF, out_ready=1 -> out_valid high 4 cycles after accept, p=0xFE01, then in_ready=1 next cycle.
REQ-031 WIDTH=8, signed, a=0x80, b=0x80 -> p=0x4000; a=0xFD (−3), b=0x05 -> p=0xFFF1 (−15); a=0x00, b=0x80 -> p=0x0000.
REQ-032 Backpressure: unsigned 0x12*0x34 with out_ready=0 for 3 cycles in DONE -> p=0x03A8 and out_valid stable all 3 cycles; new in_valid during that time ignored.
REQ-033 Reset mid-op: accept 0xAA*0x55, assert rst for 1 cycle at BUSY cycle 2 -> out_valid never rises for it, p=0, in_ready=1 after; following 0x03*0x07 -> p=0x0015.
REQ-034 WIDTH=4 exhaustive, both modes (512 ops) against reference model; WIDTH=16 random 10k ops, back-to-back in_valid held high -> every product correct, one accept per 10 cycles.
